frame_sync_ctrl: RTL

Per-frame pacing controller between the SNES core and the HDMI line-buffer output. The SNES runs slightly faster than the 720p HDMI timing. Each frame, this block halts the SNES during its DRAM refresh on an early line, then releases it once HDMI signals the start of its first active line. It owns `pause_snes_for_frame_sync`. It adds even-cycle pause alignment, a stuck-pause timeout, lock detection and optional statistics.

---
 rtl/frame_sync_ctrl_if.sv | 30 +++
 rtl/frame_sync_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/frame_sync_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | frame_sync_ctrl_if                                                       |
// | SNES/HDMI frame pacing signals grouped for frame_sync_ctrl.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface frame_sync_ctrl_if;
   logic        enable;
   logic [7:0]  ys;
   logic        snes_refresh;
   logic        hdmi_first_line;
   logic        pause_snes_for_frame_sync;
   logic        sync_done;
   logic        locked;
   logic [23:0] last_wait;
   logic [7:0]  timeout_cnt;

   modport master (
      output enable, ys, snes_refresh, hdmi_first_line,
      input  pause_snes_for_frame_sync, sync_done, locked, last_wait, timeout_cnt
   );

   modport slave (
      input  enable, ys, snes_refresh, hdmi_first_line,
      output pause_snes_for_frame_sync, sync_done, locked, last_wait, timeout_cnt
   );
endinterface

`default_nettype wire

// File: rtl/frame_sync_ctrl.sv
// +--------------------------------------------------------------------------+
// | frame_sync_ctrl                                                          |
// | Halts the SNES each frame until HDMI line 0 starts; even-length pauses,  |
// | timeout, lock detection. FRAME_SYNC_STATS_EN builds the stats registers. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module frame_sync_ctrl #(
   parameter int ARM_LINE    = 2,
   parameter int REARM_LINE  = 200,
   parameter int TIMEOUT     = 1_600_000,
   parameter int LOCK_FRAMES = 4
) (
   input  wire logic        clk,
   input  wire logic        reset,
   frame_sync_ctrl_if.slave fs
);

   localparam int          SW       = $clog2(LOCK_FRAMES + 1);
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);
   localparam logic [23:0] PCNT_MAX = 24'hFF_FFFF;
   localparam logic [7:0]  ARM_YS   = 8'(ARM_LINE);
   localparam logic [7:0]  REARM_YS = 8'(REARM_LINE);
   localparam logic [SW-1:0] LOCK_N = SW'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_PAUSED = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync2_q, sync3_q;
   logic [23:0]   pcnt_q, pcnt_d;
   logic          seen_q, seen_d;
   logic          pause_q, pause_d;
   logic          sync_done_q, sync_done_d;
   logic          locked_q, locked_d;
   logic [SW-1:0] streak_q, streak_d;

   logic          hdmi_edge;
   logic          any_seen;
   logic          rel_clean;
   logic          rel_timeout;
   logic [23:0]   pcnt_inc;

   // Release only on odd pcnt so the total pause (pcnt+1 cycles) is even.
   always_comb begin
      hdmi_edge   = sync2_q & ~sync3_q;
      any_seen    = seen_q | hdmi_edge;
      pcnt_inc    = (pcnt_q == PCNT_MAX) ? pcnt_q : pcnt_q + 24'd1;
      rel_clean   = (state_q == ST_PAUSED) && any_seen && pcnt_q[0];
      rel_timeout = (state_q == ST_PAUSED) && !any_seen &&
                    (pcnt_q >= TMO_LAST) && pcnt_q[0];
   end

   always_comb begin
      state_d     = state_q;
      pcnt_d      = pcnt_q;
      seen_d      = seen_q;
      pause_d     = pause_q;
      sync_done_d = sync_done_q;
      streak_d    = streak_q;
      if (!fs.enable) begin
         state_d     = ST_IDLE;
         pause_d     = 1'b0;
         sync_done_d = 1'b0;
         streak_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARMED;
            ST_ARMED: begin
               if ((fs.ys == ARM_YS) && fs.snes_refresh) begin
                  state_d = ST_PAUSED;
                  pause_d = 1'b1;
                  pcnt_d  = '0;
                  seen_d  = hdmi_edge;
               end
            end
            ST_PAUSED: begin
               pcnt_d = pcnt_inc;
               seen_d = any_seen;
               if (rel_clean || rel_timeout) begin
                  state_d     = ST_RUN;
                  pause_d     = 1'b0;
                  sync_done_d = 1'b1;
               end
               if (rel_clean && (streak_q != LOCK_N)) streak_d = streak_q + 1'b1;
               if (rel_timeout) streak_d = '0;
            end
            ST_RUN: begin
               if (fs.ys == REARM_YS) begin
                  state_d     = ST_ARMED;
                  sync_done_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      locked_d = (streak_d == LOCK_N);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
         pcnt_q      <= '0;
         seen_q      <= 1'b0;
         pause_q     <= 1'b0;
         sync_done_q <= 1'b0;
         locked_q    <= 1'b0;
         streak_q    <= '0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= fs.hdmi_first_line;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
         pcnt_q      <= pcnt_d;
         seen_q      <= seen_d;
         pause_q     <= pause_d;
         sync_done_q <= sync_done_d;
         locked_q    <= locked_d;
         streak_q    <= streak_d;
      end
   end

   assign fs.pause_snes_for_frame_sync = pause_q;
   assign fs.sync_done                 = sync_done_q;
   assign fs.locked                    = locked_q;

`ifdef FRAME_SYNC_STATS_EN
   logic [23:0] last_wait_q, last_wait_d;
   logic [7:0]  timeout_cnt_q, timeout_cnt_d;

   always_comb begin
      last_wait_d   = last_wait_q;
      timeout_cnt_d = timeout_cnt_q;
      if (!fs.enable) begin
         last_wait_d   = '0;
         timeout_cnt_d = '0;
      end else begin
         if (rel_clean || rel_timeout) last_wait_d = pcnt_inc;
         if (rel_timeout && (timeout_cnt_q != 8'hFF)) timeout_cnt_d = timeout_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_wait_q   <= '0;
         timeout_cnt_q <= '0;
      end else begin
         last_wait_q   <= last_wait_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign fs.last_wait   = last_wait_q;
   assign fs.timeout_cnt = timeout_cnt_q;
`else
   assign fs.last_wait   = '0;
   assign fs.timeout_cnt = '0;
`endif

endmodule

`default_nettype wire
